gba_line_cache: RTL
===================

Name: gba_line_cache

Overview:
- Line-buffer responder that sits between the GBA pixel capture path and the HDMI image generator.
- Captures 240-pixel GBA lines into a 4-line ring buffer.
- Serves the image generator's pixel-index reads with a registered 3x3 RGB neighbourhood: previous, current and next line, each at previous, current and next pixel.
- Drives the flow-control flags that the image generator uses: sameLine (hold the current line) and newFrameOut (resync to a new frame). It accepts nextLine pulses to advance the read line.

Parameters:
- LINE_WIDTH, 240, pixels per GBA line.
- FRAME_LINES, 160, lines per GBA frame.
- NUM_BUFS, 4, line buffers in the ring; must be at least 4.

Ports:
- pxlClk  in  1  pixel clock; the only clock.
- rstN  in  1  asynchronous, active-low reset.
- wrValid  in  1  one captured pixel is present on wrRed/wrGreen/wrBlue this cycle.
- wrRed  in  8  captured red component.
- wrGreen  in  8  captured green component.
- wrBlue  in  8  captured blue component.
- wrFrameStart  in  1  single-cycle pulse; starts a new GBA frame.
- nextLine  in  1  single-cycle request to advance the read line.
- curPxl  in  8  read pixel index, 0..LINE_WIDTH-1.
- nbhdOut  out  216  3x3 neighbourhood. Pixel k = 3*row+col occupies bits [24k+23:24k] as {R,G,B}. row 0/1/2 = prev/cur/next line; col 0/1/2 = prev/cur/next pixel.
- sameLine  out  1  1 = the next read line is not yet available; the reader must not advance.
- newFrameOut  out  1  level; a new frame is ready and the read position has been reset to line 0.
- overflow  out  1  sticky flag; the writer overran a buffer that the reader was using.

Behaviour:
- Reset (rstN=0, asynchronous): all counters and buffer indices = 0. nbhdOut = 0, sameLine = 1, newFrameOut = 0, overflow = 0. RAM contents are don't-care.
- Writer state:
  - wrPxl counts 0..LINE_WIDTH-1; wrBuf indexes the ring, mod NUM_BUFS; wrLinesDone counts 0..FRAME_LINES, saturating.
  - On wrValid, store the pixel at mem[wrBuf][wrPxl].
  - When wrPxl = LINE_WIDTH-1: wrPxl <= 0, wrBuf <= wrBuf+1, wrLinesDone <= wrLinesDone+1.
  - When wrLinesDone = FRAME_LINES, further pixels are dropped.
- wrFrameStart:
  - If wrPxl != 0, advance wrBuf to discard the partial line.
  - wrPxl <= 0, wrLinesDone <= 0, frameBaseBuf <= the resulting wrBuf.
  - If wrValid is high in the same cycle, frame start applies first and that pixel is stored as pixel 0 of line 0.
- Reader state: rdLine (0..FRAME_LINES-1) and rdBuf.
- Frame resync:
  - When wrLinesDone reaches 2 after a wrFrameStart: rdLine <= 0, rdBuf <= frameBaseBuf, newFrameOut <= 1.
  - newFrameOut clears on the first nextLine pulse while it is high. That pulse does not advance rdLine.
  - A new wrFrameStart while newFrameOut is still high re-arms the resync.
- sameLine:
  - Combinational from registered state: sameLine = 1 iff wrLinesDone < min(rdLine+3, FRAME_LINES), or newFrameOut = 1.
  - Consequence: lines rdLine+1 and rdLine+2 are both complete before the reader may advance.
- nextLine handling:
  - Accepted only when sameLine = 0 and rdLine < FRAME_LINES-1; then rdLine++ and rdBuf++.
  - A request while sameLine = 1, or while rdLine = FRAME_LINES-1, is ignored with no state change.
- Read latency: exactly 1 cycle. nbhdOut at cycle t+1 reflects curPxl and rdLine/rdBuf as sampled at cycle t.
  - An accepted nextLine at cycle t affects the nbhdOut presented at t+2.
- Edge clamping:
  - curPxl = 0: the prev-pixel column equals the cur-pixel column.
  - curPxl = LINE_WIDTH-1: the next-pixel column equals the cur-pixel column.
  - rdLine = 0: the prev-line row equals the cur-line row.
  - rdLine = FRAME_LINES-1: the next-line row equals the cur-line row.
  - curPxl >= LINE_WIDTH: treated as LINE_WIDTH-1.
- Overflow protection: the reader uses buffers rdBuf-1, rdBuf and rdBuf+1. When a completed write line would make wrBuf = rdBuf-1 (mod NUM_BUFS):
  - overflow <= 1;
  - the write still proceeds;
  - overflow clears only on reset.
- Storage: implementation is free (BRAM banks plus a pixel shift register, or similar), provided the 1-cycle latency and 9 pixels per cycle hold at any curPxl sequence, including non-sequential indices.

Test Plan:
- Reset check: assert rstN=0 mid-frame, then release -> nbhdOut=0, sameLine=1, newFrameOut=0, overflow=0. The first read after a new frame start returns only newly written data.
- Frame resync: send wrFrameStart, then 2 lines with pixel value = {line, pxl, 8'hA5} -> newFrameOut rises on the cycle after pixel 239 of line 1. First nextLine clears newFrameOut and leaves rdLine = 0. sameLine stays 1 until line 2 completes.
- Neighbourhood and clamping: with lines 0..2 written, rdLine=0, curPxl=0 -> next cycle the prev row equals the cur row and the prev column equals the cur column. curPxl=5 -> centre = {0,5,A5}, row 2 col 2 = {1,6,A5}. curPxl=239 -> the next column equals {x,239,A5}.
- Flow control: the writer stalls after 3 lines; pulse nextLine at rdLine=0 -> accepted, rdLine=1, sameLine=1. A second nextLine is ignored until line 3 completes.
- Frame end: at rdLine=159, nextLine -> ignored. Row 2 equals row 1. Pixels written beyond line 159 are dropped.
- Overflow and edge cases:
  - Write 3 lines beyond the reader's window without any nextLine -> overflow=1, and it stays 1 after further traffic.
  - wrFrameStart coincident with wrValid -> that pixel is read back as line 0, pixel 0.

Source files
------------

// File: rtl/gba_line_cache.sv
// GBA line cache: captures 240-pixel GBA lines into a ring of line buffers and
// serves a registered 3x3 RGB neighbourhood around (rdLine, curPxl) to the HDMI
// image generator, with sameLine/newFrameOut flow control and a sticky overflow.
module gba_line_cache #(
  parameter int unsigned LINE_WIDTH  = 240,
  parameter int unsigned FRAME_LINES = 160,
  parameter int unsigned NUM_BUFS    = 4
) (
  input  logic         pxlClk,
  input  logic         rstN,
  input  logic         wrValid,
  input  logic [7:0]   wrRed,
  input  logic [7:0]   wrGreen,
  input  logic [7:0]   wrBlue,
  input  logic         wrFrameStart,
  input  logic         nextLine,
  input  logic [7:0]   curPxl,
  output logic [215:0] nbhdOut,
  output logic         sameLine,
  output logic         newFrameOut,
  output logic         overflow
);

  localparam int unsigned PW = $clog2(LINE_WIDTH);
  localparam int unsigned LW = $clog2(FRAME_LINES + 1);
  localparam int unsigned BW = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1;

  function automatic logic [BW-1:0] buf_inc(input logic [BW-1:0] b);
    return (32'(b) == NUM_BUFS - 1) ? '0 : b + 1'b1;
  endfunction

  function automatic logic [BW-1:0] buf_dec(input logic [BW-1:0] b);
    return (b == '0) ? BW'(NUM_BUFS - 1) : b - 1'b1;
  endfunction

  // Line storage: one entry per pixel, {R,G,B}
  logic [23:0] r_mem [NUM_BUFS][LINE_WIDTH];

  // Writer state
  logic [PW-1:0] r_wr_pxl;
  logic [BW-1:0] r_wr_buf;
  logic [LW-1:0] r_wr_done;
  logic [BW-1:0] r_frame_base;
  logic          r_overflow;

  // Reader state
  logic [LW-1:0] r_rd_line;
  logic [BW-1:0] r_rd_buf;
  logic          r_armed;
  logic          r_new_frame;
  logic [215:0]  r_nbhd;

  // Writer combinational view: frame start is applied before the pixel
  logic [BW-1:0] w_fs_buf;
  logic [PW-1:0] w_eff_pxl;
  logic [BW-1:0] w_eff_buf;
  logic [LW-1:0] w_eff_done;
  logic          w_we;
  logic          w_line_end;
  logic [BW-1:0] w_nxt_buf;
  logic [LW-1:0] w_nxt_done;
  logic          w_resync;

  // Reader combinational view
  logic [31:0]   w_need;
  logic [PW-1:0] w_px_c;
  logic [PW-1:0] w_col [3];
  logic [BW-1:0] w_row [3];
  logic [215:0]  w_nbhd;

  // Effective writer position after an optional frame start in this cycle
  always_comb begin
    // A partially written line is abandoned by moving to the next buffer
    w_fs_buf   = (r_wr_pxl != '0) ? buf_inc(r_wr_buf) : r_wr_buf;
    w_eff_pxl  = wrFrameStart ? '0 : r_wr_pxl;
    w_eff_buf  = wrFrameStart ? w_fs_buf : r_wr_buf;
    w_eff_done = wrFrameStart ? '0 : r_wr_done;
    w_we       = wrValid && (32'(w_eff_done) < FRAME_LINES);
    w_line_end = w_we && (32'(w_eff_pxl) == LINE_WIDTH - 1);
    w_nxt_buf  = buf_inc(w_eff_buf);
    w_nxt_done = w_eff_done + 1'b1;
    w_resync   = r_armed && w_line_end && (w_nxt_done == LW'(2));
  end

  // Pixel store; RAM contents need no reset
  always_ff @(posedge pxlClk) begin
    if (w_we) begin
      r_mem[w_eff_buf][w_eff_pxl] <= {wrRed, wrGreen, wrBlue};
    end
  end

  // Writer counters, frame base and sticky overflow
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      r_wr_pxl     <= '0;
      r_wr_buf     <= '0;
      r_wr_done    <= '0;
      r_frame_base <= '0;
      r_overflow   <= 1'b0;
    end else begin
      if (wrFrameStart) begin
        r_frame_base <= w_fs_buf;
      end
      r_wr_pxl  <= w_eff_pxl;
      r_wr_buf  <= w_eff_buf;
      r_wr_done <= w_eff_done;
      if (w_line_end) begin
        r_wr_pxl  <= '0;
        r_wr_buf  <= w_nxt_buf;
        r_wr_done <= w_nxt_done;
        // Writer is about to start on the reader's previous-line buffer
        if (w_nxt_buf == buf_dec(r_rd_buf)) begin
          r_overflow <= 1'b1;
        end
      end else if (w_we) begin
        r_wr_pxl <= w_eff_pxl + 1'b1;
      end
    end
  end

  // Reader line position, frame resync and nextLine acceptance
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      r_rd_line   <= '0;
      r_rd_buf    <= '0;
      r_armed     <= 1'b0;
      r_new_frame <= 1'b0;
    end else begin
      if (wrFrameStart) begin
        r_armed <= 1'b1;
      end else if (w_resync) begin
        r_armed <= 1'b0;
      end
      if (w_resync) begin
        r_rd_line   <= '0;
        r_rd_buf    <= r_frame_base;
        r_new_frame <= 1'b1;
      end else if (nextLine) begin
        // The pulse that acknowledges a new frame does not advance the line
        if (r_new_frame) begin
          r_new_frame <= 1'b0;
        end else if (!sameLine && (32'(r_rd_line) < FRAME_LINES - 1)) begin
          r_rd_line <= r_rd_line + 1'b1;
          r_rd_buf  <= buf_inc(r_rd_buf);
        end
      end
    end
  end

  // Hold the reader until lines rdLine+1 and rdLine+2 are complete
  always_comb begin
    w_need   = (32'(r_rd_line) + 3 > FRAME_LINES) ? FRAME_LINES : 32'(r_rd_line) + 3;
    sameLine = r_new_frame || (32'(r_wr_done) < w_need);
  end

  // Clamped 3x3 addresses and the nine pixel reads
  always_comb begin
    w_px_c   = (32'(curPxl) >= LINE_WIDTH) ? PW'(LINE_WIDTH - 1) : PW'(curPxl);
    w_col[0] = (w_px_c == '0) ? w_px_c : w_px_c - 1'b1;
    w_col[1] = w_px_c;
    w_col[2] = (32'(w_px_c) == LINE_WIDTH - 1) ? w_px_c : w_px_c + 1'b1;
    w_row[0] = (r_rd_line == '0) ? r_rd_buf : buf_dec(r_rd_buf);
    w_row[1] = r_rd_buf;
    w_row[2] = (32'(r_rd_line) == FRAME_LINES - 1) ? r_rd_buf : buf_inc(r_rd_buf);
    w_nbhd   = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        w_nbhd[24*(3*r+c) +: 24] = r_mem[w_row[r]][w_col[c]];
      end
    end
  end

  // One-cycle registered neighbourhood output
  always_ff @(posedge pxlClk or negedge rstN) begin
    if (!rstN) begin
      r_nbhd <= '0;
    end else begin
      r_nbhd <= w_nbhd;
    end
  end

  assign nbhdOut     = r_nbhd;
  assign newFrameOut = r_new_frame;
  assign overflow    = r_overflow;

endmodule
